// File: rtl/otter_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : otter_fetch_unit
//  Purpose  : Instruction fetch front end. Issues one-cycle-latency reads to
//             instruction memory under a credit rule and buffers returned
//             words in a circular queue that feeds decode. Redirects flush
//             the queue and squash any read already in flight.
//  Revision : 1.0 - initial release
// ============================================================================
module otter_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        REDIRECT,
   input  logic [31:0] REDIRECT_PC,
   output logic [31:0] IMEM_ADDR,
   output logic        IMEM_RD,
   input  logic [31:0] IMEM_DOUT,
   output logic        DE_VALID,
   input  logic        DE_READY,
   output logic [31:0] DE_IR,
   output logic [31:0] DE_PC
);

   // Pointer width; count needs one extra bit to represent a full queue.
   localparam int c_ptr_w = $clog2(DEPTH);
   localparam int c_cnt_w = c_ptr_w + 1;

   localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
   localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
   localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(DEPTH);

   logic [31:0]        r_fpc;
   logic               r_infl;
   logic [31:0]        r_tag;
   logic               r_sq;
   logic [c_ptr_w-1:0] r_rd_ptr;
   logic [c_ptr_w-1:0] r_wr_ptr;
   logic [c_cnt_w-1:0] r_count;
   logic [31:0]        r_q_ir [DEPTH];
   logic [31:0]        r_q_pc [DEPTH];

   logic               w_pop;
   logic               w_push;
   logic               w_issue;
   logic [c_cnt_w-1:0] w_credit;
   logic               w_unused;

   // The low two address bits of a redirect target are always forced to zero.
   assign w_unused = ^REDIRECT_PC[1:0];

   // Decode handshake: the head is offered unless a flush or reset is underway.
   assign DE_VALID = (r_count != '0) && !REDIRECT && !RST;
   assign DE_IR    = r_q_ir[r_rd_ptr];
   assign DE_PC    = r_q_pc[r_rd_ptr];
   assign w_pop    = DE_VALID && DE_READY;

   // Entries already owed to the queue: stored words plus the read in flight,
   // less the one leaving this cycle. A pop implies count>=1, so no underflow.
   assign w_credit = r_count + c_cnt_w'(r_infl) - c_cnt_w'(w_pop);
   assign w_issue  = !RST && !REDIRECT && (w_credit < c_depth);

   assign IMEM_RD   = w_issue;
   assign IMEM_ADDR = RST ? RESET_PC : r_fpc;

   // A returning word is kept only if its stream has not been flushed.
   assign w_push = r_infl && !r_sq && !REDIRECT && !RST;

   // Control state: fetch PC, in-flight tracking, squash flag and queue pointers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fpc    <= RESET_PC;
         r_infl   <= 1'b0;
         r_tag    <= RESET_PC;
         r_sq     <= 1'b0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (REDIRECT) begin
         r_fpc    <= {REDIRECT_PC[31:2], 2'b00};
         r_sq     <= r_infl;
         r_infl   <= 1'b0;
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_sq <= 1'b0;
         if (w_issue) begin
            r_fpc  <= r_fpc + 32'd4;
            r_infl <= 1'b1;
            r_tag  <= r_fpc;
         end else begin
            r_infl <= 1'b0;
         end
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_ptr_one;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_ptr_one;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + c_cnt_one;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - c_cnt_one;
         end
      end
   end

   // Queue storage: capture the returned word together with its fetch address.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_q_ir[r_wr_ptr] <= IMEM_DOUT;
         r_q_pc[r_wr_ptr] <= r_tag;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_otter_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_otter_fetch_unit
//  Purpose  : Self-checking bench for otter_fetch_unit: a cycle table of
//             directed vectors, a wrap-around instance, and a randomized run
//             checked against an in-order instruction stream model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_otter_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST;
   logic        REDIRECT;
   logic [31:0] REDIRECT_PC;
   logic [31:0] IMEM_ADDR;
   logic        IMEM_RD;
   logic [31:0] IMEM_DOUT;
   logic        DE_VALID;
   logic        DE_READY;
   logic [31:0] DE_IR;
   logic [31:0] DE_PC;

   logic [31:0] imem_addr2;
   logic        imem_rd2;
   logic [31:0] imem_dout2;
   logic        de_valid2;
   logic [31:0] de_ir2;
   logic [31:0] de_pc2;

   int n_checks = 0;
   int n_errors = 0;

   always #5 CLK = ~CLK;

   otter_fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
      .CLK(CLK), .RST(RST), .REDIRECT(REDIRECT), .REDIRECT_PC(REDIRECT_PC),
      .IMEM_ADDR(IMEM_ADDR), .IMEM_RD(IMEM_RD), .IMEM_DOUT(IMEM_DOUT),
      .DE_VALID(DE_VALID), .DE_READY(DE_READY), .DE_IR(DE_IR), .DE_PC(DE_PC)
   );

   otter_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_wrap (
      .CLK(CLK), .RST(RST), .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
      .IMEM_ADDR(imem_addr2), .IMEM_RD(imem_rd2), .IMEM_DOUT(imem_dout2),
      .DE_VALID(de_valid2), .DE_READY(1'b1), .DE_IR(de_ir2), .DE_PC(de_pc2)
   );

   // Instruction memory: word at address A is A + 0x100, one cycle after read.
   always @(posedge CLK) begin
      if (IMEM_RD) IMEM_DOUT <= IMEM_ADDR + 32'h100;
      if (imem_rd2) imem_dout2 <= imem_addr2 + 32'h100;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rst;
      logic        redir;
      logic [31:0] rpc;
      logic        rdy;
      logic        e_rd;
      logic [31:0] e_addr;
      logic        e_val;
      logic [31:0] e_pc;
   } vec_t;

   localparam int NV = 25;
   vec_t tbl [NV];

   function automatic vec_t mkv(input logic rst, input logic redir, input logic [31:0] rpc,
                                input logic rdy, input logic e_rd, input logic [31:0] e_addr,
                                input logic e_val, input logic [31:0] e_pc);
      vec_t v;
      v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy;
      v.e_rd = e_rd; v.e_addr = e_addr; v.e_val = e_val; v.e_pc = e_pc;
      return v;
   endfunction

   logic [31:0] wrap_pc [4];
   logic [31:0] exp_next;
   int          starve;
   logic        r_rst;
   logic        r_redir;
   logic [31:0] r_rpc;

   initial begin
      // Stall fill, drain, redirect with queue occupied, then a mid-stream reset.
      tbl[0] = mkv(0, 0, 0, 0, 1, 32'h0,  0, 0);
      tbl[1] = mkv(0, 0, 0, 0, 1, 32'h4,  0, 0);
      tbl[2] = mkv(0, 0, 0, 0, 1, 32'h8,  1, 0);
      tbl[3] = mkv(0, 0, 0, 0, 1, 32'hC,  1, 0);
      for (int i = 4; i < 10; i++) tbl[i] = mkv(0, 0, 0, 0, 0, 32'h10, 1, 0);
      tbl[10] = mkv(0, 0, 0, 1, 1, 32'h10, 1, 32'h0);
      tbl[11] = mkv(0, 0, 0, 1, 1, 32'h14, 1, 32'h4);
      tbl[12] = mkv(0, 0, 0, 1, 1, 32'h18, 1, 32'h8);
      tbl[13] = mkv(0, 0, 0, 1, 1, 32'h1C, 1, 32'hC);
      tbl[14] = mkv(0, 0, 0, 1, 1, 32'h20, 1, 32'h10);
      tbl[15] = mkv(0, 0, 0, 1, 1, 32'h24, 1, 32'h14);
      tbl[16] = mkv(0, 1, 32'h203, 1, 0, 32'h28, 0, 0);
      tbl[17] = mkv(0, 0, 0, 1, 1, 32'h200, 0, 0);
      tbl[18] = mkv(0, 0, 0, 1, 1, 32'h204, 0, 0);
      tbl[19] = mkv(0, 0, 0, 1, 1, 32'h208, 1, 32'h200);
      tbl[20] = mkv(0, 0, 0, 1, 1, 32'h20C, 1, 32'h204);
      tbl[21] = mkv(1, 0, 0, 1, 0, 32'h0,  0, 0);
      tbl[22] = mkv(0, 0, 0, 1, 1, 32'h0,  0, 0);
      tbl[23] = mkv(0, 0, 0, 1, 1, 32'h4,  0, 0);
      tbl[24] = mkv(0, 0, 0, 1, 1, 32'h8,  1, 32'h0);

      wrap_pc[0] = 32'hFFFF_FFF8;
      wrap_pc[1] = 32'hFFFF_FFFC;
      wrap_pc[2] = 32'h0000_0000;
      wrap_pc[3] = 32'h0000_0004;

      RST = 1'b1; REDIRECT = 1'b0; REDIRECT_PC = 32'h0; DE_READY = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      chk("reset_rd",    {31'h0, IMEM_RD},  32'h0);
      chk("reset_valid", {31'h0, DE_VALID}, 32'h0);
      chk("reset_addr",  IMEM_ADDR,         32'h0);
      chk("reset_addr_wrap", imem_addr2,    32'hFFFF_FFF8);
      @(posedge CLK);

      for (int i = 0; i < NV; i++) begin
         #1;
         RST = tbl[i].rst; REDIRECT = tbl[i].redir;
         REDIRECT_PC = tbl[i].rpc; DE_READY = tbl[i].rdy;
         @(negedge CLK);
         chk($sformatf("tbl%0d_rd", i),    {31'h0, IMEM_RD},  {31'h0, tbl[i].e_rd});
         chk($sformatf("tbl%0d_addr", i),  IMEM_ADDR,         tbl[i].e_addr);
         chk($sformatf("tbl%0d_valid", i), {31'h0, DE_VALID}, {31'h0, tbl[i].e_val});
         if (tbl[i].e_val) begin
            chk($sformatf("tbl%0d_pc", i), DE_PC, tbl[i].e_pc);
            chk($sformatf("tbl%0d_ir", i), DE_IR, tbl[i].e_pc + 32'h100);
         end
         if (i >= 2 && i < 6) begin
            chk($sformatf("wrap%0d_valid", i), {31'h0, de_valid2}, 32'h1);
            chk($sformatf("wrap%0d_pc", i),    de_pc2, wrap_pc[i-2]);
            chk($sformatf("wrap%0d_ir", i),    de_ir2, wrap_pc[i-2] + 32'h100);
         end
         @(posedge CLK);
      end

      // Randomized run: every accepted instruction must continue the stream
      // from the last reset/redirect target, in order, with matching memory data.
      exp_next = 32'h0;
      starve   = 0;
      for (int k = 0; k < 4000; k++) begin
         #1;
         r_rst   = (k == 0) || ($urandom_range(0, 99) == 0);
         r_redir = !r_rst && ($urandom_range(0, 9) == 0);
         r_rpc   = $urandom;
         RST = r_rst; REDIRECT = r_redir; REDIRECT_PC = r_rpc;
         DE_READY = ($urandom_range(0, 9) < 7);
         @(negedge CLK);
         chk("rnd_addr_align", {30'h0, IMEM_ADDR[1:0]}, 32'h0);
         if (r_rst || r_redir) begin
            chk("rnd_flush_valid", {31'h0, DE_VALID}, 32'h0);
            chk("rnd_flush_rd",    {31'h0, IMEM_RD},  32'h0);
         end
         if (DE_VALID && DE_READY) begin
            chk("rnd_pc", DE_PC, exp_next);
            chk("rnd_ir", DE_IR, exp_next + 32'h100);
            exp_next = exp_next + 32'd4;
         end
         if (DE_VALID) begin
            starve = 0;
         end else if (DE_READY && !r_rst && !r_redir) begin
            starve++;
            chk("rnd_bubble_bound", {31'h0, (starve > 2)}, 32'h0);
         end
         if (r_rst) begin
            exp_next = 32'h0;
            starve   = 0;
         end else if (r_redir) begin
            exp_next = {r_rpc[31:2], 2'b00};
            starve   = 0;
         end
         @(posedge CLK);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/otter_fetch_unit.md
OTTER_FETCH_UNIT -- requirements
Module: otter_fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, which is the instruction queue depth; DEPTH SHALL be a power of two and at least 2.
REQ-003 CLK  input  1  the single clock; all state SHALL update on its rising edge.
REQ-004 RST  input  1  reset; it SHALL be synchronous and active-high.
REQ-005 REDIRECT  input  1  flush request from execute (taken branch, JAL, JALR, trap).
REQ-006 REDIRECT_PC  input  32  new fetch target; bits [1:0] SHALL be ignored and treated as 00.
REQ-007 IMEM_ADDR  output  32  instruction-memory read address.
REQ-008 IMEM_RD  output  1  instruction-memory read strobe.
REQ-009 IMEM_DOUT  input  32  read data; it SHALL be valid exactly one cycle after the cycle in which IMEM_RD=1.
REQ-010 DE_VALID  output  1  the queue head is offered to decode.
REQ-011 DE_READY  input  1  decode accepts the offered instruction.
REQ-012 DE_IR  output  32  instruction word at the queue head.
REQ-013 DE_PC  output  32  address of DE_IR.

Function
REQ-014 State SHALL consist of: fetch PC fpc; an in-flight flag infl with a tag PC; a squash flag sq; and a circular queue of DEPTH entries of {ir, pc} with read pointer, write pointer and count (0..DEPTH).
REQ-015 A transfer to decode (pop) SHALL occur when DE_VALID=1 and DE_READY=1.
REQ-016 DE_VALID SHALL equal (count!=0) AND NOT REDIRECT.
REQ-017 DE_IR and DE_PC SHALL come from the queue head and SHALL hold steady while DE_VALID=1 and DE_READY=0.
REQ-018 A read SHALL be issued (IMEM_RD=1) when RST=0, REDIRECT=0 and (count + infl - pop) < DEPTH.
REQ-019 IMEM_ADDR SHALL equal fpc in every cycle.
REQ-020 On an issue, fpc SHALL advance to fpc+4 modulo 2^32 (0xFFFF_FFFC wraps to 0); infl SHALL be set to 1 and the tag SHALL be set to the issued fpc.
REQ-021 With no issue, infl SHALL be cleared and fpc SHALL hold.
REQ-022 In the cycle after an issue, if sq=0 and REDIRECT=0, {IMEM_DOUT, tag} SHALL be pushed at the write pointer.
REQ-023 If sq=1 or REDIRECT=1 in that return cycle, the returned word SHALL be discarded.
REQ-024 Simultaneous push and pop SHALL leave count unchanged, with both pointers advancing modulo DEPTH.
REQ-025 A push SHALL never occur when count=DEPTH; this is guaranteed by the credit rule in REQ-018.
REQ-026 A pop SHALL never occur when count=0.
REQ-027 Redirect cycle (REDIRECT=1): no issue and no pop; the queue SHALL be emptied (count and pointers set to 0); fpc SHALL be set to {REDIRECT_PC[31:2], 2'b00}; sq SHALL be set to 1 if infl=1; infl SHALL be cleared.
REQ-028 The first read of the new stream SHALL issue in the cycle after REDIRECT.
REQ-029 sq SHALL clear one cycle after it is set; consecutive REDIRECT cycles SHALL each reload fpc, and the last REDIRECT_PC wins.
REQ-030 Latency: an instruction issued in cycle N SHALL appear with DE_VALID=1 in cycle N+2, absent stalls and redirects.
REQ-031 Throughput SHALL be one instruction per cycle while DE_READY=1.
REQ-032 The instruction stream SHALL be delivered in order, with each DE_PC equal to the previous DE_PC + 4 unless a REDIRECT intervenes.

Reset
REQ-033 While RST=1: fpc = RESET_PC, infl=0, sq=0, count=0, pointers=0, IMEM_RD=0, DE_VALID=0, IMEM_ADDR=RESET_PC.
REQ-034 RST SHALL take priority over REDIRECT and over any pending response.
REQ-035 A response returning in the first cycle after RST deasserts SHALL be discarded.
REQ-036 The first issue SHALL occur in the first cycle with RST=0, at address RESET_PC.
REQ-037 DE_IR and DE_PC SHALL be don't-care while DE_VALID=0.

Verification
REQ-038 Reset release, DE_READY=1, memory word at address A = 0x100+A -> IMEM_RD=1 from cycle 0; DE_VALID=1 from cycle 2 with DE_PC=0, 4, 8, ... and DE_IR=0x100, 0x104, 0x108, ... on consecutive cycles.
REQ-039 DE_READY=0 for 10 cycles after reset -> count saturates at 4; IMEM_RD drops to 0 once count+infl=4; DE_PC holds at 0.
REQ-040 DE_READY=1 again after that stall -> PCs 0, 4, 8, 12, 16 delivered on consecutive cycles with no gap and no duplicate.
REQ-041 REDIRECT=1 with REDIRECT_PC=0x0000_0203 while 3 entries are queued and one read is in flight -> DE_VALID=0 in the redirect cycle and the next two cycles; IMEM_ADDR=0x200 on the next cycle; DE_PC=0x200 two cycles after that; no stale PC is ever delivered.
REQ-042 RESET_PC=0xFFFF_FFF8, DE_READY=1 -> DE_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
REQ-043 RST asserted for one cycle mid-stream with a read in flight -> DE_VALID=0 for 2 cycles after release, then DE_PC=RESET_PC.
